// File: rtl/des_sched_pkg.sv
// Shared types and constants for the DES block scheduler: FSM encodings and seed slicing.
package des_sched_pkg;

    localparam int unsigned SEED_W     = 64;
    localparam int unsigned MAX_BLOCKS = 16;

    typedef enum logic [1:0] {
        StIdle,
        StDispatch,
        StDrain,
        StDone
    } top_state_e;

    typedef enum logic [1:0] {
        SlotIdle,
        SlotRun,
        SlotRelease
    } slot_state_e;

    // Low bit of block idx's slice within the packed blk_seed bus.
    function automatic int unsigned seed_lo(input int unsigned idx);
        return idx * SEED_W;
    endfunction

endpackage

// File: rtl/des_block_scheduler_if.sv
// Host command, status and des_block array signals of the scheduler.
// master drives commands and blk_valid; slave is the scheduler.
interface des_block_scheduler_if #(
    parameter int unsigned N_BLOCKS = 4,
    parameter int unsigned JOB_W    = 16
);

    logic                                        cmd_start;
    logic [des_sched_pkg::SEED_W-1:0]            cmd_base_seed;
    logic [JOB_W-1:0]                            cmd_num_jobs;
    logic                                        busy;
    logic                                        done;
    logic [JOB_W-1:0]                            jobs_dispatched;
    logic [JOB_W-1:0]                            jobs_completed;
    logic [N_BLOCKS-1:0]                         blk_start;
    logic [des_sched_pkg::SEED_W*N_BLOCKS-1:0]   blk_seed;
    logic [N_BLOCKS-1:0]                         blk_valid;

    modport master (
        output cmd_start, cmd_base_seed, cmd_num_jobs, blk_valid,
        input  busy, done, jobs_dispatched, jobs_completed, blk_start, blk_seed
    );

    modport slave (
        input  cmd_start, cmd_base_seed, cmd_num_jobs, blk_valid,
        output busy, done, jobs_dispatched, jobs_completed, blk_start, blk_seed
    );

endinterface

// File: rtl/des_slot_ctrl.sv
// Per-block slot controller: holds start and the seed of one des_block for the length of a job.
module des_slot_ctrl
    import des_sched_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              grant,
    input  logic [SEED_W-1:0] seed,
    input  logic              blk_valid,
    output logic              idle,
    output logic              complete,
    output logic              blk_start,
    output logic [SEED_W-1:0] blk_seed
);

    slot_state_e       state_q;
    logic              start_q;
    logic [SEED_W-1:0] seed_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= SlotIdle;
            start_q <= 1'b0;
            seed_q  <= '0;
        end else begin
            unique case (state_q)
                SlotIdle: begin
                    if (grant) begin
                        state_q <= SlotRun;
                        start_q <= 1'b1;
                        seed_q  <= seed;
                    end
                end
                SlotRun: begin
                    if (blk_valid) begin
                        state_q <= SlotRelease;
                        start_q <= 1'b0;
                    end
                end
                SlotRelease: begin
                    if (grant) begin
                        state_q <= SlotRun;
                        start_q <= 1'b1;
                        seed_q  <= seed;
                    end else begin
                        state_q <= SlotIdle;
                    end
                end
                default: begin
                    state_q <= SlotIdle;
                    start_q <= 1'b0;
                end
            endcase
        end
    end

    // A releasing slot may be granted: the new start only rises after its one low cycle.
    assign idle      = (state_q != SlotRun);
    assign complete  = (state_q == SlotRun) && blk_valid;
    assign blk_start = start_q;
    assign blk_seed  = seed_q;

endmodule

// File: rtl/des_block_scheduler.sv
// Dispatches a batch of seeded jobs across N_BLOCKS des_block slots and reports completion.
// Define DES_SCHED_PERF_EN to add the saturating busy-cycle counter output cycle_count.
module des_block_scheduler
    import des_sched_pkg::*;
#(
    parameter int unsigned N_BLOCKS = 4,
    parameter int unsigned JOB_W    = 16
) (
    input logic                  clk,
    input logic                  rst_n,
    des_block_scheduler_if.slave bus
`ifdef DES_SCHED_PERF_EN
    ,
    output logic [31:0]          cycle_count
`endif
);

    top_state_e          state_q;
    logic                busy_q;
    logic                done_q;
    logic [SEED_W-1:0]   base_q;
    logic [JOB_W-1:0]    num_q;
    logic [JOB_W-1:0]    disp_q;
    logic [JOB_W-1:0]    comp_q;
    logic [JOB_W-1:0]    disp_d;
    logic [JOB_W-1:0]    comp_d;
    logic [JOB_W-1:0]    n_comp;
    logic [N_BLOCKS-1:0] slot_idle;
    logic [N_BLOCKS-1:0] slot_complete;
    logic [N_BLOCKS-1:0] slot_start;
    logic [N_BLOCKS-1:0] grant;
    logic                accept;
    logic                dispatch_en;
    logic                found;
    logic [SEED_W-1:0]   next_seed;

    assign accept      = (state_q == StIdle) && bus.cmd_start;
    assign dispatch_en = (accept && (bus.cmd_num_jobs != '0)) ||
                         ((state_q == StDispatch) && (disp_q != num_q));
    // Job 0 goes out on the accepting edge, straight from the command inputs.
    assign next_seed   = (state_q == StIdle) ? bus.cmd_base_seed : base_q + SEED_W'(disp_q);

    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < int'(N_BLOCKS); i++) begin
            if (dispatch_en && slot_idle[i] && !found) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    always_comb begin
        n_comp = '0;
        for (int i = 0; i < int'(N_BLOCKS); i++) begin
            n_comp = n_comp + JOB_W'(slot_complete[i]);
        end
    end

    assign disp_d = disp_q + JOB_W'(found);
    assign comp_d = comp_q + n_comp;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            base_q  <= '0;
            num_q   <= '0;
            disp_q  <= '0;
            comp_q  <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.cmd_start) begin
                        base_q  <= bus.cmd_base_seed;
                        num_q   <= bus.cmd_num_jobs;
                        disp_q  <= JOB_W'(found);
                        comp_q  <= '0;
                        busy_q  <= 1'b1;
                        // An empty batch passes through DRAIN so it still shows one busy cycle.
                        state_q <= (bus.cmd_num_jobs == '0) ? StDrain : StDispatch;
                    end
                end
                StDispatch: begin
                    disp_q <= disp_d;
                    comp_q <= comp_d;
                    if (disp_d == num_q) begin
                        if (comp_d == num_q) begin
                            state_q <= StDone;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    comp_q <= comp_d;
                    if (comp_d == num_q) begin
                        state_q <= StDone;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    for (genvar i = 0; i < N_BLOCKS; i++) begin : g_slot
        logic [SEED_W-1:0] slot_seed;

        des_slot_ctrl u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .grant     (grant[i]),
            .seed      (next_seed),
            .blk_valid (bus.blk_valid[i]),
            .idle      (slot_idle[i]),
            .complete  (slot_complete[i]),
            .blk_start (slot_start[i]),
            .blk_seed  (slot_seed)
        );

        assign bus.blk_seed[seed_lo(i) +: SEED_W] = slot_seed;
    end

    assign bus.blk_start       = slot_start;
    assign bus.busy            = busy_q;
    assign bus.done            = done_q;
    assign bus.jobs_dispatched = disp_q;
    assign bus.jobs_completed  = comp_q;

`ifdef DES_SCHED_PERF_EN
    logic [31:0] cycle_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cycle_q <= '0;
        end else if (accept) begin
            cycle_q <= '0;
        end else if (busy_q && (cycle_q != '1)) begin
            cycle_q <= cycle_q + 32'd1;
        end
    end

    assign cycle_count = cycle_q;
`endif

endmodule

// File: tb/tb_des_block_scheduler.sv
// Scoreboard bench for des_block_scheduler: dispatch seeds and done pulses are checked by a monitor.
module tb_des_block_scheduler;

    localparam int unsigned NB = 4;
    localparam int unsigned JW = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    des_block_scheduler_if #(.N_BLOCKS(NB), .JOB_W(JW)) bus ();

`ifdef DES_SCHED_PERF_EN
    logic [31:0] cycle_count;
`endif

    des_block_scheduler #(
        .N_BLOCKS (NB),
        .JOB_W    (JW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus)
`ifdef DES_SCHED_PERF_EN
        ,
        .cycle_count (cycle_count)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] exp_seed_q[$];
    int          exp_done_q[$];

    logic          stub_en;
    int            stub_lat;
    logic [NB-1:0] stub_v;
    logic [NB-1:0] man_v;
    int            stub_cnt [NB];

    assign bus.blk_valid = stub_en ? stub_v : man_v;

    logic [63:0] ov_seeds [10] = '{
        64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h1, 64'h2,
        64'h3, 64'h4, 64'h5, 64'h6, 64'h7
    };

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [63:0] base, input logic [15:0] num);
        bus.cmd_base_seed = base;
        bus.cmd_num_jobs  = num;
        bus.cmd_start     = 1'b1;
        cyc();
        bus.cmd_start     = 1'b0;
    endtask

    task automatic wait_done(input int k0, input int kmax, output int k);
        k = k0;
        while (!bus.done && k < kmax) begin
            cyc();
            k++;
        end
        if (!bus.done) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: no done within %0d cycles", kmax);
        end
    endtask

    // Stub des_block: valid for one cycle once start has been high for stub_lat cycles.
    initial begin
        stub_v = '0;
        for (int i = 0; i < NB; i++) stub_cnt[i] = 0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NB; i++) begin
                if (!bus.blk_start[i]) begin
                    stub_cnt[i] = 0;
                    stub_v[i]   = 1'b0;
                end else begin
                    stub_cnt[i] = stub_cnt[i] + 1;
                    stub_v[i]   = (stub_cnt[i] == stub_lat);
                end
            end
        end
    end

    initial begin : monitor
        logic [NB-1:0] prev;
        logic [63:0]   e_seed;
        int            e_done;
        prev = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < NB; i++) begin
                if (bus.blk_start[i] && !prev[i]) begin
                    if (exp_seed_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_dispatch: slot %0d seed 0x%0h, none expected",
                                 i, bus.blk_seed[i*64 +: 64]);
                    end else begin
                        e_seed = exp_seed_q.pop_front();
                        check($sformatf("dispatch_seed_slot%0d", i), bus.blk_seed[i*64 +: 64],
                              e_seed);
                    end
                end
            end
            prev = bus.blk_start;
            if (bus.done) begin
                if (exp_done_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done, expected none");
                end else begin
                    e_done = exp_done_q.pop_front();
                    check("done_jobs_completed", 64'(bus.jobs_completed), 64'(e_done));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        bus.cmd_start     = 1'b0;
        bus.cmd_base_seed = '0;
        bus.cmd_num_jobs  = '0;
        stub_en  = 1'b1;
        stub_lat = 5;
        man_v    = '0;

        rst_n = 1'b0;
        repeat (2) cyc();
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_done", 64'(bus.done), 64'd0);
        check("reset_dispatched", 64'(bus.jobs_dispatched), 64'd0);
        check("reset_completed", 64'(bus.jobs_completed), 64'd0);
        check("reset_blk_start", 64'(bus.blk_start), 64'd0);
        check("reset_blk_seed_any", 64'(|bus.blk_seed), 64'd0);
`ifdef DES_SCHED_PERF_EN
        check("reset_cycle_count", 64'(cycle_count), 64'd0);
`endif
        rst_n = 1'b1;
        cyc();

        // Single job, 3-cycle block latency.
        stub_lat = 3;
        exp_seed_q.push_back(64'h2);
        exp_done_q.push_back(1);
        issue(64'h2, 16'd1);
        check("single_busy_t1", 64'(bus.busy), 64'd1);
        check("single_blk_start_t1", 64'(bus.blk_start), 64'b0001);
        check("single_seed0_t1", bus.blk_seed[63:0], 64'h2);
        check("single_dispatched_t1", 64'(bus.jobs_dispatched), 64'd1);
        wait_done(1, 30, k);
        check("single_done_cycle", 64'(k), 64'd4);
        check("single_busy_at_done", 64'(bus.busy), 64'd0);
        repeat (3) cyc();

        // Oversubscription with seed wrap-around.
        stub_lat = 5;
        for (int i = 0; i < 10; i++) exp_seed_q.push_back(ov_seeds[i]);
        exp_done_q.push_back(10);
        issue(64'hFFFF_FFFF_FFFF_FFFE, 16'd10);
        wait_done(1, 100, k);
        check("over_done_cycle", 64'(k), 64'd19);
        check("over_dispatched", 64'(bus.jobs_dispatched), 64'd10);
        check("over_completed", 64'(bus.jobs_completed), 64'd10);
        repeat (5) cyc();

        // Simultaneous completions driven by hand.
        stub_en = 1'b0;
        for (int i = 0; i < 8; i++) exp_seed_q.push_back(64'h100 + 64'(i));
        exp_done_q.push_back(8);
        issue(64'h100, 16'd8);
        repeat (4) cyc();
        check("simul_all_running", 64'(bus.blk_start), 64'hF);
        man_v = 4'hF;
        cyc();
        man_v = 4'h0;
        check("simul_completed_plus4", 64'(bus.jobs_completed), 64'd4);
        check("simul_start_low", 64'(bus.blk_start), 64'h0);
        cyc();
        check("simul_restart_t7", 64'(bus.blk_start), 64'b0001);
        cyc();
        check("simul_restart_t8", 64'(bus.blk_start), 64'b0011);
        cyc();
        check("simul_restart_t9", 64'(bus.blk_start), 64'b0111);
        cyc();
        check("simul_restart_t10", 64'(bus.blk_start), 64'b1111);
        check("simul_dispatched", 64'(bus.jobs_dispatched), 64'd8);
        cyc();
        check("simul_completed_hold", 64'(bus.jobs_completed), 64'd4);
        man_v = 4'hF;
        cyc();
        man_v = 4'h0;
        check("simul_done", 64'(bus.done), 64'd1);
        stub_en = 1'b1;
        repeat (3) cyc();

        // Empty batch.
        exp_done_q.push_back(0);
        issue(64'hABC, 16'd0);
        check("empty_busy_t1", 64'(bus.busy), 64'd1);
        check("empty_done_t1", 64'(bus.done), 64'd0);
        cyc();
        check("empty_done_t2", 64'(bus.done), 64'd1);
        check("empty_busy_t2", 64'(bus.busy), 64'd0);
        check("empty_blk_start", 64'(bus.blk_start), 64'd0);
        repeat (3) cyc();

        // cmd_start while busy is ignored.
        stub_lat = 5;
        for (int i = 0; i < 3; i++) exp_seed_q.push_back(64'h50 + 64'(i));
        exp_done_q.push_back(3);
        issue(64'h50, 16'd3);
        cyc();
        bus.cmd_base_seed = 64'h999;
        bus.cmd_num_jobs  = 16'd9;
        bus.cmd_start     = 1'b1;
        cyc();
        bus.cmd_start     = 1'b0;
        check("ignored_dispatched", 64'(bus.jobs_dispatched), 64'd3);
        check("ignored_busy", 64'(bus.busy), 64'd1);
        wait_done(3, 40, k);
        check("ignored_done_cycle", 64'(k), 64'd8);
        check("ignored_completed", 64'(bus.jobs_completed), 64'd3);
`ifdef DES_SCHED_PERF_EN
        check("perf_count_at_done", 64'(cycle_count), 64'd7);
        repeat (3) cyc();
        check("perf_count_hold", 64'(cycle_count), 64'd7);
`else
        repeat (3) cyc();
`endif
        repeat (2) cyc();

        // Reset in the middle of DISPATCH.
        exp_seed_q.push_back(64'h0);
        exp_seed_q.push_back(64'h1);
        issue(64'h0, 16'd6);
        cyc();
        rst_n = 1'b0;
        cyc();
        check("midrst_blk_start", 64'(bus.blk_start), 64'd0);
        check("midrst_dispatched", 64'(bus.jobs_dispatched), 64'd0);
        check("midrst_completed", 64'(bus.jobs_completed), 64'd0);
        check("midrst_busy", 64'(bus.busy), 64'd0);
        check("midrst_blk_seed_any", 64'(|bus.blk_seed), 64'd0);
        rst_n = 1'b1;
        repeat (6) cyc();
        check("midrst_stays_idle", 64'(bus.busy), 64'd0);

        check("seed_queue_left", 64'(exp_seed_q.size()), 64'd0);
        check("done_queue_left", 64'(exp_done_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
